// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with a sequenced zero-clear mode.
// Build option: REGFILE_ZERO_FILTER_EN suppresses writes to index 0 and skips it during clear.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_wR,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 regWrite,
  output logic [AW-1:0]        wR,
  output logic [DW-1:0]        writeData,
  output logic [1:0]           grant_id
);

  typedef enum logic {ARB, CLEAR} state_t;

`ifdef REGFILE_ZERO_FILTER_EN
  localparam logic [AW-1:0] CLR_FIRST = AW'(1);
`else
  localparam logic [AW-1:0] CLR_FIRST = '0;
`endif

  state_t          state_q;
  logic [1:0]      ptr_q;
  logic [AW-1:0]   cnt_q;
  logic            busy_q;
  logic            regWrite_q;
  logic [AW-1:0]   wR_q;
  logic [DW-1:0]   writeData_q;
  logic [1:0]      grant_q;

  logic            arb_en;
  logic            found_d;
  logic [1:0]      sel_d;
  logic [1:0]      idx;
  logic [AW-1:0]   sel_wR;
  logic [DW-1:0]   sel_data;

  assign arb_en = (state_q == ARB) && !clear_start && !reset;

  // Scan from the requester after the last winner, wrapping; first valid one wins.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    idx     = '0;
    if (arb_en) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx = 2'((32'(ptr_q) + k) % NREQ);
        if (!found_d && req_valid[idx]) begin
          found_d = 1'b1;
          sel_d   = idx;
        end
      end
    end
  end

  assign req_ready = found_d ? (NREQ'(1) << sel_d) : '0;
  assign sel_wR    = req_wR[sel_d*AW +: AW];
  assign sel_data  = req_data[sel_d*DW +: DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      ptr_q       <= 2'(NREQ - 1);
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      regWrite_q  <= 1'b0;
      wR_q        <= '0;
      writeData_q <= '0;
      grant_q     <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (clear_start) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            cnt_q      <= CLR_FIRST;
            regWrite_q <= 1'b0;
          end else if (found_d) begin
            grant_q <= sel_d;
            ptr_q   <= sel_d;
`ifdef REGFILE_ZERO_FILTER_EN
            // Accepted but dropped: index 0 is hardwired zero in this build.
            regWrite_q <= (sel_wR != '0);
            if (sel_wR != '0) begin
              wR_q        <= sel_wR;
              writeData_q <= sel_data;
            end
`else
            regWrite_q  <= 1'b1;
            wR_q        <= sel_wR;
            writeData_q <= sel_data;
`endif
          end else begin
            regWrite_q <= 1'b0;
          end
        end
        CLEAR: begin
          regWrite_q  <= 1'b1;
          wR_q        <= cnt_q;
          writeData_q <= '0;
          if (cnt_q == '1) begin
            state_q <= ARB;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign clear_busy = busy_q;
  assign regWrite   = regWrite_q;
  assign wR         = wR_q;
  assign writeData  = writeData_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue/array reference model plus directed literal checks and random traffic.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
`ifdef REGFILE_ZERO_FILTER_EN
  localparam int CLR_LO = 1;
`else
  localparam int CLR_LO = 0;
`endif
  localparam int CLR_N = 32 - CLR_LO;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*AW-1:0] req_wR;
  logic [NREQ*DW-1:0] req_data;
  logic clear_start, clear_busy, regWrite;
  logic [AW-1:0] wR;
  logic [DW-1:0] writeData;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wR(req_wR), .req_data(req_data), .clear_start(clear_start),
    .clear_busy(clear_busy), .regWrite(regWrite), .wR(wR),
    .writeData(writeData), .grant_id(grant_id)
  );

  // Requester side: each holds one pending write until it is accepted.
  bit            pend_v [NREQ];
  logic [AW-1:0] pend_wR[NREQ];
  logic [DW-1:0] pend_d [NREQ];

  // Model: a clear is a queued list of per-cycle output tuples; otherwise plain RR.
  typedef struct { bit rw; int wr; bit busy; } clr_t;
  clr_t clr_q[$];
  int            m_ptr;
  bit            e_rw, e_busy;
  logic [AW-1:0] e_wR;
  logic [DW-1:0] e_wd;
  int            e_gid;
  logic [NREQ-1:0] last_ready;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = NREQ - 1;
    clr_q.delete();
    e_rw = 0; e_busy = 0; e_wR = '0; e_wd = '0; e_gid = 0;
  endtask

  function automatic int model_pick();
    if (clr_q.size() != 0 || clear_start) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (pend_v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input bit cs);
    int w;
    logic [NREQ-1:0] er;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend_v[i];
      req_wR[i*AW +: AW]    = pend_wR[i];
      req_data[i*DW +: DW]  = pend_d[i];
    end
    clear_start = cs;
    #1;
    w  = model_pick();
    er = (w < 0) ? '0 : (NREQ'(1) << w);
    last_ready = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("regWrite", 64'(regWrite), 64'(e_rw));
    chk("wR", 64'(wR), 64'(e_wR));
    chk("writeData", 64'(writeData), 64'(e_wd));
    chk("grant_id", 64'(grant_id), 64'(e_gid));
    chk("clear_busy", 64'(clear_busy), 64'(e_busy));
    @(posedge clk);
    if (clr_q.size() != 0) begin
      clr_t c;
      c = clr_q.pop_front();
      e_rw = c.rw; e_busy = c.busy;
      if (c.rw) begin e_wR = AW'(c.wr); e_wd = '0; end
    end else if (cs) begin
      for (int k = CLR_LO; k <= 31; k++) clr_q.push_back('{1'b1, k, k != 31});
      e_rw = 0; e_busy = 1;
    end else if (w >= 0) begin
      e_gid = w; m_ptr = w;
`ifdef REGFILE_ZERO_FILTER_EN
      e_rw = (pend_wR[w] != 0);
      if (pend_wR[w] != 0) begin e_wR = pend_wR[w]; e_wd = pend_d[w]; end
`else
      e_rw = 1; e_wR = pend_wR[w]; e_wd = pend_d[w];
`endif
      pend_v[w] = 0;
    end else begin
      e_rw = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_start = 1'b0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 0;
    req_valid = '0;
    #1;
    chk("rst_regWrite", 64'(regWrite), 64'(0));
    chk("rst_busy", 64'(clear_busy), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
    pend_v[i] = 1; pend_wR[i] = AW'(a); pend_d[i] = d;
  endtask

  initial begin
    int gseq[6];
    int rwcnt, busycnt, clrw;
    bit rw_s[40], busy_s[40];
    int wr_s[40], gid_s[40];
    logic [DW-1:0] wd_s[40];

    reset = 1'b1; clear_start = 0; req_valid = '0; req_wR = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) begin pend_v[i] = 0; pend_wR[i] = '0; pend_d[i] = '0; end
    model_reset();
    do_reset();

    // Single write from requester 0.
    set_req(0, 8, 32'h12);
    step(0);
    chk("t1_ready", 64'(last_ready), 64'(3'b001));
    #2;
    chk("t1_regWrite", 64'(regWrite), 64'(1));
    chk("t1_wR", 64'(wR), 64'(8));
    chk("t1_data", 64'(writeData), 64'(32'h12));
    chk("t1_gid", 64'(grant_id), 64'(0));

    // All requesters continuously valid: rotation 0,1,2,0,1,2.
    do_reset();
    rwcnt = 0;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NREQ; i++) if (!pend_v[i]) set_req(i, 1 + i, $urandom);
      step(0);
      #2;
      gseq[j] = grant_id;
      rwcnt += int'(regWrite);
    end
    for (int j = 0; j < 6; j++) chk($sformatf("t2_gid%0d", j), 64'(gseq[j]), 64'(j % 3));
    chk("t2_rwcnt", 64'(rwcnt), 64'(6));

    // After a grant to 1, requester 2 beats 0.
    do_reset();
    set_req(1, 3, 32'hA1);
    step(0); #2; chk("t3_gid_a", 64'(grant_id), 64'(1));
    set_req(0, 4, 32'hB0); set_req(2, 5, 32'hB2);
    step(0); #2; chk("t3_gid_b", 64'(grant_id), 64'(2));
    step(0); #2; chk("t3_gid_c", 64'(grant_id), 64'(0));

    // Clear with requester 1 waiting.
    do_reset();
    set_req(1, 9, 32'hCAFE_0001);
    step(1);
    chk("t4_ready", 64'(last_ready), 64'(0));
    #2;
    rw_s[0] = regWrite; busy_s[0] = clear_busy; wr_s[0] = wR; wd_s[0] = writeData; gid_s[0] = grant_id;
    for (int j = 1; j <= CLR_N + 1; j++) begin
      step(0); #2;
      rw_s[j] = regWrite; busy_s[j] = clear_busy; wr_s[j] = wR; wd_s[j] = writeData; gid_s[j] = grant_id;
    end
    busycnt = 0; clrw = 0;
    for (int j = 0; j <= CLR_N + 1; j++) busycnt += int'(busy_s[j]);
    for (int j = 1; j <= CLR_N; j++)
      if (rw_s[j] && wd_s[j] == 0 && wr_s[j] == j - 1 + CLR_LO) clrw++;
    chk("t4_busycnt", 64'(busycnt), 64'(CLR_N));
    chk("t4_clr_writes", 64'(clrw), 64'(CLR_N));
    chk("t4_first_rw", 64'(rw_s[0]), 64'(0));
    chk("t4_post_rw", 64'(rw_s[CLR_N + 1]), 64'(1));
    chk("t4_post_gid", 64'(gid_s[CLR_N + 1]), 64'(1));
    chk("t4_post_data", 64'(wd_s[CLR_N + 1]), 64'(32'hCAFE_0001));

    // Reset in the middle of a clear.
    do_reset();
    step(1);
    for (int j = 0; j < 10; j++) step(0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_regWrite", 64'(regWrite), 64'(0));
    chk("t5_busy", 64'(clear_busy), 64'(0));
    chk("t5_wR", 64'(wR), 64'(0));
    #4;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, $urandom);
    step(0);
    chk("t5_ready", 64'(last_ready), 64'(3'b001));

`ifdef REGFILE_ZERO_FILTER_EN
    do_reset();
    set_req(0, 0, 32'hFF);
    step(0);
    chk("t6_ready", 64'(last_ready), 64'(3'b001));
    #2;
    chk("t6_regWrite", 64'(regWrite), 64'(0));
`endif

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && $urandom_range(1, 0) == 1)
          set_req(i, int'($urandom_range(31, 0)), $urandom);
      step($urandom_range(39, 0) == 0);
    end
    step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
